// File: rtl/pad_mux_pkg.sv
// Shared types and width helpers for the pad ownership scheduler.
// Holds the scheduler state encoding and the default pad owner.
package pad_mux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISOLATE = 3'd1,
    ST_SWITCH  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int DEFAULT_OWNER = 0;

  // Width of an owner select; a single owner still needs one bit.
  function automatic int sel_width(input int n_periph);
    return (n_periph > 1) ? $clog2(n_periph) : 1;
  endfunction

  function automatic int idx_width(input int n_io);
    return (n_io > 1) ? $clog2(n_io) : 1;
  endfunction

endpackage

// File: rtl/pad_mux_xbar.sv
// Combinational per-pad owner mux and pad-input demux.
// A set force bit parks the pad: output and enable low, input routed to nobody.
module pad_mux_xbar #(
  parameter int N_IO     = 48,
  parameter int N_PERIPH = 4,
  parameter int SW       = 2
) (
  input  logic [N_IO*SW-1:0]       sel_i,
  input  logic [N_IO-1:0]          force_i,
  input  logic [N_PERIPH*N_IO-1:0] periph_out_i,
  input  logic [N_PERIPH*N_IO-1:0] periph_oe_i,
  input  logic [N_IO-1:0]          io_in_i,
  output logic [N_IO-1:0]          io_out_o,
  output logic [N_IO-1:0]          io_oe_o,
  output logic [N_PERIPH*N_IO-1:0] periph_in_o
);

  for (genvar i = 0; i < N_IO; i++) begin : g_pad
    logic [SW-1:0] s;
    logic          out_v;
    logic          oe_v;

    assign s = sel_i[i*SW +: SW];

    always_comb begin
      out_v = 1'b0;
      oe_v  = 1'b0;
      for (int p = 0; p < N_PERIPH; p++) begin
        if (s == SW'(p)) begin
          out_v = periph_out_i[p*N_IO+i];
          oe_v  = periph_oe_i[p*N_IO+i];
        end
      end
    end

    assign io_out_o[i] = out_v & ~force_i[i];
    assign io_oe_o[i]  = oe_v & ~force_i[i];

    for (genvar p = 0; p < N_PERIPH; p++) begin : g_in
      assign periph_in_o[p*N_IO+i] = io_in_i[i] & ~force_i[i] & (s == SW'(p));
    end
  end

endmodule

// File: rtl/pad_mux_sched.sv
// Pad ownership scheduler: per-pad owner/config registers with break-before-make switching.
// Optional per-pad lock storage is built when PAD_MUX_LOCK_EN is defined.
module pad_mux_sched
  import pad_mux_pkg::*;
#(
  parameter int N_IO        = 48,
  parameter int N_PERIPH    = 4,
  parameter int NBIT_PADCFG = 6,
  parameter int GUARD_CYC   = 2,
  localparam int SW         = sel_width(N_PERIPH),
  localparam int IW         = idx_width(N_IO)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [N_PERIPH*N_IO-1:0]      periph_out_i,
  input  logic [N_PERIPH*N_IO-1:0]      periph_oe_i,
  output logic [N_PERIPH*N_IO-1:0]      periph_in_o,
  input  logic [N_IO-1:0]               io_in_i,
  output logic [N_IO-1:0]               io_out_o,
  output logic [N_IO-1:0]               io_oe_o,
  output logic [N_IO*NBIT_PADCFG-1:0]   pad_cfg_o,
  input  logic                          cfg_req_i,
  output logic                          cfg_ready_o,
  input  logic [IW-1:0]                 cfg_idx_i,
  input  logic [SW-1:0]                 cfg_sel_i,
  input  logic [NBIT_PADCFG-1:0]        cfg_padcfg_i,
  input  logic                          cfg_lock_i,
  output logic                          cfg_done_o,
  output logic                          cfg_err_o,
  output state_t                        dbg_state_o
);

  localparam int CW = $clog2(GUARD_CYC + 1);

  // Handshake: a request transfers on a cycle where cfg_req_i and cfg_ready_o
  // are both high; ready is high only in IDLE with no error pulse pending.
  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N_IO*SW-1:0]         sel_q;
  logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_q;
  logic [IW-1:0]              idx_q;
  logic [SW-1:0]              new_sel_q;
  logic [NBIT_PADCFG-1:0]     new_cfg_q;
  logic                       same_q;
  logic                       err_q;
  logic [SW-1:0]              cur_sel;
  logic                       cur_lock;
  logic                       accept;
  logic                       reject;
  logic                       same;
  logic                       force_active;
  logic [N_IO-1:0]            force_mask;

`ifdef PAD_MUX_LOCK_EN
  logic [N_IO-1:0]            lock_q;
  logic                       new_lock_q;
`else
  logic                       unused_lock;
  assign unused_lock = cfg_lock_i;
`endif

  always_comb begin
    cur_sel  = SW'(DEFAULT_OWNER);
    cur_lock = 1'b0;
    for (int i = 0; i < N_IO; i++) begin
      if (cfg_idx_i == IW'(i)) begin
        cur_sel = sel_q[i*SW +: SW];
`ifdef PAD_MUX_LOCK_EN
        cur_lock = lock_q[i];
`endif
      end
    end
  end

  assign cfg_ready_o = (state_q == ST_IDLE) && !err_q;
  assign accept      = cfg_req_i && cfg_ready_o;
  assign reject      = (32'(cfg_idx_i) >= 32'(N_IO)) || cur_lock;
  assign same        = (cur_sel == cfg_sel_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !reject) begin
          if (same) begin
            state_d = ST_SWITCH;
          end else begin
            state_d = ST_ISOLATE;
            cnt_d   = CW'(GUARD_CYC - 1);
          end
        end
      end
      ST_ISOLATE: begin
        if (cnt_q == '0) state_d = ST_SWITCH;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_SWITCH: begin
        if (same_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(GUARD_CYC - 1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      pad_cfg_q <= '0;
      idx_q     <= '0;
      new_sel_q <= '0;
      new_cfg_q <= '0;
      same_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PAD_MUX_LOCK_EN
      lock_q     <= '0;
      new_lock_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= accept && reject;
      if (accept && !reject) begin
        idx_q     <= cfg_idx_i;
        new_sel_q <= cfg_sel_i;
        new_cfg_q <= cfg_padcfg_i;
        same_q    <= same;
`ifdef PAD_MUX_LOCK_EN
        new_lock_q <= cfg_lock_i;
`endif
      end
      if (state_q == ST_SWITCH) begin
        for (int i = 0; i < N_IO; i++) begin
          if (idx_q == IW'(i)) begin
            sel_q[i*SW +: SW]                     <= new_sel_q;
            pad_cfg_q[i*NBIT_PADCFG +: NBIT_PADCFG] <= new_cfg_q;
`ifdef PAD_MUX_LOCK_EN
            lock_q[i] <= lock_q[i] | new_lock_q;
`endif
          end
        end
      end
    end
  end

  // A same-owner update passes through SWITCH without parking the pad.
  assign force_active = (state_q == ST_ISOLATE) || (state_q == ST_SETTLE) ||
                        ((state_q == ST_SWITCH) && !same_q);

  always_comb begin
    force_mask = '0;
    for (int i = 0; i < N_IO; i++) begin
      if (force_active && (idx_q == IW'(i))) force_mask[i] = 1'b1;
    end
  end

  pad_mux_xbar #(
    .N_IO     (N_IO),
    .N_PERIPH (N_PERIPH),
    .SW       (SW)
  ) u_xbar (
    .sel_i        (sel_q),
    .force_i      (force_mask),
    .periph_out_i (periph_out_i),
    .periph_oe_i  (periph_oe_i),
    .io_in_i      (io_in_i),
    .io_out_o     (io_out_o),
    .io_oe_o      (io_oe_o),
    .periph_in_o  (periph_in_o)
  );

  assign pad_cfg_o   = pad_cfg_q;
  assign cfg_done_o  = (state_q == ST_DONE);
  assign cfg_err_o   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pad_mux_sched.sv
// Self-checking bench for pad_mux_sched: reference owner/config model plus a
// queue of expected {owner, padcfg} results popped on each cfg_done_o pulse.
module tb_pad_mux_sched;
  import pad_mux_pkg::*;

  localparam int N_IO = 48;
  localparam int NP   = 4;
  localparam int NB   = 6;
  localparam int G    = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NP*N_IO-1:0]   periph_out_i, periph_oe_i, periph_in_o;
  logic [N_IO-1:0]      io_in_i, io_out_o, io_oe_o;
  logic [N_IO*NB-1:0]   pad_cfg_o;
  logic                 cfg_req_i, cfg_ready_o, cfg_lock_i, cfg_done_o, cfg_err_o;
  logic [5:0]           cfg_idx_i;
  logic [1:0]           cfg_sel_i;
  logic [NB-1:0]        cfg_padcfg_i;
  state_t               dbg_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  int         m_sel[N_IO];
  logic [5:0] m_cfg[N_IO];

  always #5 clk = ~clk;

  pad_mux_sched #(.N_IO(N_IO), .N_PERIPH(NP), .NBIT_PADCFG(NB), .GUARD_CYC(G)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .periph_out_i(periph_out_i), .periph_oe_i(periph_oe_i), .periph_in_o(periph_in_o),
    .io_in_i(io_in_i), .io_out_o(io_out_o), .io_oe_o(io_oe_o), .pad_cfg_o(pad_cfg_o),
    .cfg_req_i(cfg_req_i), .cfg_ready_o(cfg_ready_o), .cfg_idx_i(cfg_idx_i),
    .cfg_sel_i(cfg_sel_i), .cfg_padcfg_i(cfg_padcfg_i), .cfg_lock_i(cfg_lock_i),
    .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o), .dbg_state_o(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [N_IO-1:0] m_io(input int fidx, input bit want_oe);
    logic [N_IO-1:0] r;
    r = '0;
    for (int i = 0; i < N_IO; i++)
      if (i != fidx) r[i] = want_oe ? periph_oe_i[m_sel[i]*N_IO+i] : periph_out_i[m_sel[i]*N_IO+i];
    return r;
  endfunction

  function automatic logic [NP*N_IO-1:0] m_pin(input int fidx);
    logic [NP*N_IO-1:0] r;
    r = '0;
    for (int i = 0; i < N_IO; i++)
      if (i != fidx) r[m_sel[i]*N_IO+i] = io_in_i[i];
    return r;
  endfunction

  function automatic logic [N_IO*NB-1:0] m_cfgv();
    logic [N_IO*NB-1:0] r;
    for (int i = 0; i < N_IO; i++) r[i*NB +: NB] = m_cfg[i];
    return r;
  endfunction

  function automatic logic [2:0] probe_owner(input int idx);
    for (int p = 0; p < NP; p++)
      if (periph_in_o[p*N_IO+idx]) return 3'(p);
    return 3'd7;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    for (int i = 0; i < N_IO; i++) begin
      m_sel[i] = 0;
      m_cfg[i] = '0;
    end
  endtask

  task automatic rand_bus();
    for (int k = 0; k < NP*N_IO; k++) begin
      periph_out_i[k] = 1'($urandom_range(0, 1));
      periph_oe_i[k]  = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < N_IO; k++) io_in_i[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input int idx, input int sel, input int cfg, input int lock);
    cfg_idx_i    = 6'(idx);
    cfg_sel_i    = 2'(sel);
    cfg_padcfg_i = 6'(cfg);
    cfg_lock_i   = 1'(lock);
    cfg_req_i    = 1'b1;
    tick();
    cfg_req_i    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; cfg_req_i = 1'b0; cfg_idx_i = '0; cfg_sel_i = '0;
    cfg_padcfg_i = '0; cfg_lock_i = 1'b0;
    periph_out_i = '0; periph_oe_i = '0; io_in_i = '0;
    repeat (3) tick();
    rstn = 1'b1;
    model_reset();
    periph_out_i[0*N_IO+5] = 1'b1;
    periph_oe_i[0*N_IO+5]  = 1'b1;
    io_in_i[5] = 1'b1;
    @(negedge clk);
    checks++; if (io_out_o[5] !== 1'b1) begin errors++; $display("FAIL reset_io_out5: got %b want 1", io_out_o[5]); end
    checks++; if (io_oe_o[5] !== 1'b1) begin errors++; $display("FAIL reset_io_oe5: got %b want 1", io_oe_o[5]); end
    checks++; if (pad_cfg_o !== '0) begin errors++; $display("FAIL reset_pad_cfg: got %h want 0", pad_cfg_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready_o); end
    checks++; if ({cfg_done_o, cfg_err_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {cfg_done_o, cfg_err_o}); end
    checks++; if (periph_in_o !== m_pin(-1)) begin errors++; $display("FAIL reset_periph_in: got %h want %h", periph_in_o, m_pin(-1)); end
    tick();
  endtask

  task automatic test_switch();
    int fidx;
    logic [8:0] exp_v, got;
    exp_q.push_back({3'd2, 6'h15});
    send_req(5, 2, 'h15, 0);
    for (int c = 1; c <= 2*G+3; c++) begin
      rand_bus();
      if (c == 2*G+2) io_in_i[5] = 1'b1;
      if (c == G+2) begin m_sel[5] = 2; m_cfg[5] = 6'h15; end
      fidx = (c <= 2*G+1) ? 5 : -1;
      @(negedge clk);
      checks++; if (io_out_o !== m_io(fidx, 0)) begin errors++; $display("FAIL switch_io_out c%0d: got %h want %h", c, io_out_o, m_io(fidx, 0)); end
      checks++; if (io_oe_o !== m_io(fidx, 1)) begin errors++; $display("FAIL switch_io_oe c%0d: got %h want %h", c, io_oe_o, m_io(fidx, 1)); end
      checks++; if (periph_in_o !== m_pin(fidx)) begin errors++; $display("FAIL switch_periph_in c%0d: got %h want %h", c, periph_in_o, m_pin(fidx)); end
      checks++; if (pad_cfg_o !== m_cfgv()) begin errors++; $display("FAIL switch_pad_cfg c%0d: got %h want %h", c, pad_cfg_o, m_cfgv()); end
      checks++; if (cfg_done_o !== (c == 2*G+2)) begin errors++; $display("FAIL switch_done c%0d: got %b want %b", c, cfg_done_o, (c == 2*G+2)); end
      checks++; if (cfg_ready_o !== (c >= 2*G+3)) begin errors++; $display("FAIL switch_ready c%0d: got %b want %b", c, cfg_ready_o, (c >= 2*G+3)); end
      if (cfg_done_o) begin
        got = {probe_owner(5), pad_cfg_o[5*NB +: NB]};
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        checks++; if (got !== exp_v) begin errors++; $display("FAIL switch_result: got %h want %h", got, exp_v); end
      end
      tick();
    end
  endtask

  task automatic test_same_owner();
    logic [8:0] exp_v, got;
    exp_q.push_back({3'd2, 6'h01});
    send_req(5, 2, 'h01, 0);
    for (int c = 1; c <= 3; c++) begin
      rand_bus();
      if (c == 2) begin io_in_i[5] = 1'b1; m_cfg[5] = 6'h01; end
      @(negedge clk);
      checks++; if (io_oe_o !== m_io(-1, 1)) begin errors++; $display("FAIL same_io_oe c%0d: got %h want %h", c, io_oe_o, m_io(-1, 1)); end
      checks++; if (pad_cfg_o !== m_cfgv()) begin errors++; $display("FAIL same_pad_cfg c%0d: got %h want %h", c, pad_cfg_o, m_cfgv()); end
      checks++; if (cfg_done_o !== (c == 2)) begin errors++; $display("FAIL same_done c%0d: got %b want %b", c, cfg_done_o, (c == 2)); end
      checks++; if (cfg_ready_o !== (c >= 3)) begin errors++; $display("FAIL same_ready c%0d: got %b want %b", c, cfg_ready_o, (c >= 3)); end
      if (cfg_done_o) begin
        got = {probe_owner(5), pad_cfg_o[5*NB +: NB]};
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        checks++; if (got !== exp_v) begin errors++; $display("FAIL same_result: got %h want %h", got, exp_v); end
      end
      tick();
    end
  endtask

  task automatic test_reject();
    send_req(48, 1, 'h3f, 0);
    for (int c = 1; c <= 2; c++) begin
      rand_bus();
      @(negedge clk);
      checks++; if (cfg_err_o !== (c == 1)) begin errors++; $display("FAIL reject_err c%0d: got %b want %b", c, cfg_err_o, (c == 1)); end
      checks++; if (cfg_ready_o !== (c == 2)) begin errors++; $display("FAIL reject_ready c%0d: got %b want %b", c, cfg_ready_o, (c == 2)); end
      checks++; if (cfg_done_o !== 1'b0) begin errors++; $display("FAIL reject_done c%0d: got %b want 0", c, cfg_done_o); end
      checks++; if (io_out_o !== m_io(-1, 0)) begin errors++; $display("FAIL reject_io_out c%0d: got %h want %h", c, io_out_o, m_io(-1, 0)); end
      checks++; if (pad_cfg_o !== m_cfgv()) begin errors++; $display("FAIL reject_pad_cfg c%0d: got %h want %h", c, pad_cfg_o, m_cfgv()); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    send_req(9, 1, 'h2a, 0);
    for (int c = 1; c <= 2; c++) begin
      rand_bus();
      @(negedge clk);
      checks++; if (io_oe_o !== m_io(9, 1)) begin errors++; $display("FAIL rmid_forced c%0d: got %h want %h", c, io_oe_o, m_io(9, 1)); end
      tick();
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    model_reset();
    rand_bus();
    @(negedge clk);
    checks++; if (pad_cfg_o !== '0) begin errors++; $display("FAIL rmid_pad_cfg: got %h want 0", pad_cfg_o); end
    checks++; if (io_out_o !== m_io(-1, 0)) begin errors++; $display("FAIL rmid_io_out: got %h want %h", io_out_o, m_io(-1, 0)); end
    checks++; if (io_oe_o !== m_io(-1, 1)) begin errors++; $display("FAIL rmid_io_oe: got %h want %h", io_oe_o, m_io(-1, 1)); end
    checks++; if (periph_in_o !== m_pin(-1)) begin errors++; $display("FAIL rmid_periph_in: got %h want %h", periph_in_o, m_pin(-1)); end
    checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", cfg_ready_o); end
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (cfg_done_o || cfg_err_o) saw_done = 1'b1;
      tick();
      @(negedge clk);
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse: got %b want 0", saw_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    int idx, sel, cfg, lat, cyc, w;
    logic [8:0] exp_v, got;
    for (int n = 0; n < 8; n++) begin
      idx = $urandom_range(0, N_IO-1);
      sel = (n % 3 == 0) ? m_sel[idx] : $urandom_range(0, NP-1);
      cfg = $urandom_range(0, 63);
      lat = (sel == m_sel[idx]) ? 2 : 2*G+2;
      w = 0;
      while (!cfg_ready_o && w < 40) begin tick(); w++; end
      checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_timeout n%0d: got %b want 1", n, cfg_ready_o); end
      exp_q.push_back({3'(sel), 6'(cfg)});
      send_req(idx, sel, cfg, 0);
      io_in_i = '0;
      io_in_i[idx] = 1'b1;
      cyc = 1;
      @(negedge clk);
      while (!cfg_done_o && cyc < lat + 6) begin
        tick(); cyc++;
        @(negedge clk);
      end
      checks++; if (cyc !== lat) begin errors++; $display("FAIL b2b_latency n%0d: got %0d want %0d", n, cyc, lat); end
      m_sel[idx] = sel;
      m_cfg[idx] = 6'(cfg);
      got = {probe_owner(idx), pad_cfg_o[idx*NB +: NB]};
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
      checks++; if (got !== exp_v) begin errors++; $display("FAIL b2b_result n%0d: got %h want %h", n, got, exp_v); end
      checks++; if (pad_cfg_o !== m_cfgv()) begin errors++; $display("FAIL b2b_pad_cfg n%0d: got %h want %h", n, pad_cfg_o, m_cfgv()); end
      checks++; if (io_out_o !== m_io(-1, 0)) begin errors++; $display("FAIL b2b_io_out n%0d: got %h want %h", n, io_out_o, m_io(-1, 0)); end
      tick();
    end
  endtask

`ifdef PAD_MUX_LOCK_EN
  task automatic test_lock();
    int cyc;
    send_req(7, 1, 'h0c, 1);
    repeat (2*G+2) tick();
    m_sel[7] = 1; m_cfg[7] = 6'h0c;
    send_req(7, 3, 'h3f, 0);
    @(negedge clk);
    checks++; if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL lock_err: got %b want 1", cfg_err_o); end
    checks++; if (pad_cfg_o !== m_cfgv()) begin errors++; $display("FAIL lock_pad_cfg: got %h want %h", pad_cfg_o, m_cfgv()); end
    tick();
    rstn = 1'b0; tick(); rstn = 1'b1;
    model_reset();
    send_req(7, 3, 'h3f, 0);
    cyc = 1;
    @(negedge clk);
    while (!cfg_done_o && cyc < 2*G+8) begin tick(); cyc++; @(negedge clk); end
    checks++; if (cyc !== 2*G+2) begin errors++; $display("FAIL lock_after_reset: got %0d want %0d", cyc, 2*G+2); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_switch();
    test_same_owner();
    test_reject();
    test_reset_mid();
    test_back_to_back();
`ifdef PAD_MUX_LOCK_EN
    test_lock();
`endif
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
